// File: rtl/ps2_direction_encoder.sv
// PS/2 keyboard front end: receives frames, tracks held arrow keys and emits
// one-hot direction strobes (immediate + auto-repeat), new_game and frame_error.
module ps2_direction_encoder #(
  parameter int unsigned REPEAT_CYCLES  = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] direction,
  output logic       new_game,
  output logic       frame_error
);

  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_SPACE = 8'h29;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_CHECK
  } rx_state_e;

  // Held-key bit positions match the one-hot direction encoding.
  function automatic logic [3:0] arrow_onehot(input logic [7:0] code);
    case (code)
      8'h74:   arrow_onehot = 4'b0001;
      8'h6B:   arrow_onehot = 4'b0010;
      8'h75:   arrow_onehot = 4'b0100;
      8'h72:   arrow_onehot = 4'b1000;
      default: arrow_onehot = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] lowest_set(input logic [3:0] v);
    lowest_set = v & (~v + 4'd1);
  endfunction

  // ---------------------------------------------------------------------------
  // Pin synchronizers and falling-edge detect
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;
  logic       fall_q;
  logic       bit_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      // NOTE: PS/2 lines idle high; resetting these to 1 avoids a false edge
      // on the first cycles after reset release.
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
      bit_q       <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
      fall_q      <= clk_prev_q & ~clk_sync_q[1];
      bit_q       <= data_sync_q[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  rx_state_e       rx_state_q;
  logic [3:0]      bit_cnt_q;
  logic [8:0]      shreg_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            frame_error_q;
  logic            rx_valid;
  logic [7:0]      rx_byte;

  // Byte is handed to the decoder in the stop-bit edge cycle itself.
  assign rx_byte  = shreg_q[7:0];
  assign rx_valid = (rx_state_q == RX_CHECK) && fall_q && bit_q && (^shreg_q);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_state_q    <= RX_IDLE;
      bit_cnt_q     <= 4'd0;
      shreg_q       <= 9'd0;
      to_cnt_q      <= '0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      if (fall_q) begin
        to_cnt_q <= '0;
        case (rx_state_q)
          RX_IDLE: begin
            if (!bit_q) begin
              rx_state_q <= RX_SHIFT;
              bit_cnt_q  <= 4'd0;
            end else begin
              frame_error_q <= 1'b1;
            end
          end
          RX_SHIFT: begin
            shreg_q   <= {bit_q, shreg_q[8:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd8) rx_state_q <= RX_CHECK;
          end
          RX_CHECK: begin
            if (!rx_valid) frame_error_q <= 1'b1;
            rx_state_q <= RX_IDLE;
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end else if (rx_state_q != RX_IDLE) begin
        if (to_cnt_q == TO_LAST) begin
          rx_state_q    <= RX_IDLE;
          frame_error_q <= 1'b1;
          to_cnt_q      <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code decoder, held-key tracking and repeat timer
  // ---------------------------------------------------------------------------
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [3:0]       held_q, held_d;
  logic [3:0]       last_q, last_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [3:0]       dir_q, dir_d;
  logic             new_game_q, new_game_d;
  logic [3:0]       arrow_key;
  logic             make_strobe;

  assign arrow_key = arrow_onehot(rx_byte);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    ext_d       = ext_q;
    brk_d       = brk_q;
    held_d      = held_q;
    last_d      = last_q;
    rep_cnt_d   = rep_cnt_q;
    dir_d       = 4'b0000;
    new_game_d  = 1'b0;
    make_strobe = 1'b0;

    if (rx_valid) begin
      if (rx_byte == CODE_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == CODE_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (ext_q && (arrow_key != 4'b0000)) begin
          if (!brk_q) begin
            // A make for an already-held key is keyboard typematic: ignored.
            if ((held_q & arrow_key) == 4'b0000) begin
              held_d      = held_q | arrow_key;
              last_d      = arrow_key;
              make_strobe = 1'b1;
            end
          end else begin
            held_d = held_q & ~arrow_key;
            if (last_q == arrow_key) last_d = lowest_set(held_d);
          end
        end else if (!ext_q && !brk_q && (rx_byte == CODE_SPACE)) begin
          new_game_d = 1'b1;
        end
      end
    end

    // A make strobe wins over a coincident repeat tick and restarts the timer.
    if (make_strobe) begin
      rep_cnt_d = '0;
      dir_d     = last_d;
    end else if (held_d == 4'b0000) begin
      rep_cnt_d = '0;
    end else if (rep_cnt_q == REP_LAST) begin
      rep_cnt_d = '0;
      dir_d     = last_d;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      held_q     <= 4'b0000;
      last_q     <= 4'b0000;
      rep_cnt_q  <= '0;
      dir_q      <= 4'b0000;
      new_game_q <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      held_q     <= held_d;
      last_q     <= last_d;
      rep_cnt_q  <= rep_cnt_d;
      dir_q      <= dir_d;
      new_game_q <= new_game_d;
    end
  end

  assign direction   = dir_q;
  assign new_game    = new_game_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_direction_encoder.sv
// Directed testbench for ps2_direction_encoder: bit-banged PS/2 frames with
// expected strobe timing derived from the bench's own stop-bit edge times.
module tb_ps2_direction_encoder;

  localparam int REP  = 100;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] direction;
  logic       new_game;
  logic       frame_error;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         dir_t[$];
  logic [3:0] dir_v[$];
  int         ng_t[$];
  int         fe_t[$];
  bit         bad_dir = 1'b0;
  int         last_stop;
  int         last_drop;

  ps2_direction_encoder #(
    .REPEAT_CYCLES (REP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .direction  (direction),
    .new_game   (new_game),
    .frame_error(frame_error)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Output log, sampled on the falling clock edge.
  always @(negedge clk_in) begin
    if (!reset) begin
      if (direction != 4'b0000) begin
        dir_t.push_back(cyc);
        dir_v.push_back(direction);
        if ($countones(direction) > 1) bad_dir = 1'b1;
      end
      if (new_game) ng_t.push_back(cyc);
      if (frame_error) fe_t.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic clear_logs();
    dir_t.delete();
    dir_v.delete();
    ng_t.delete();
    fe_t.delete();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_in);
  endtask

  // Sends the first nbits bits of a frame (start, 8 data, parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_in);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk_in);
      ps2_clk   = 1'b0;
      last_drop = cyc;
      repeat (HALF) @(negedge clk_in);
      ps2_clk = 1'b1;
    end
    last_stop = last_drop;
    repeat (HALF) @(negedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk_in);
    checks++;
    if (direction !== 4'b0000) begin errors++; $display("FAIL reset_direction: got %b want 0000", direction); end
    checks++;
    if (new_game !== 1'b0) begin errors++; $display("FAIL reset_new_game: got %b want 0", new_game); end
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
    reset = 1'b0;
    clear_logs();
    repeat (20) @(negedge clk_in);
    checks++;
    if (dir_t.size() + ng_t.size() + fe_t.size() != 0) begin
      errors++;
      $display("FAIL idle_after_reset: got %0d strobes want 0", dir_t.size() + ng_t.size() + fe_t.size());
    end
  endtask

  task automatic test_right_repeat();
    int t0, tb, late;
    clear_logs();
    send_byte(8'hE0);
    send_byte(8'h74);
    t0 = last_stop + 4;
    wait_until(t0 + 350);
    checks++;
    if (dir_t.size() != 4) begin
      errors++;
      $display("FAIL right_repeat_count: got %0d strobes want 4", dir_t.size());
    end
    for (int i = 0; i < 4 && i < dir_t.size(); i++) begin
      checks++;
      if (dir_t[i] != t0 + REP * i || dir_v[i] !== 4'b0001) begin
        errors++;
        $display("FAIL right_strobe_%0d: got %b at %0d want 0001 at %0d", i, dir_v[i], dir_t[i], t0 + REP * i);
      end
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    tb = last_stop + 4;
    wait_until(tb + 300);
    late = 0;
    foreach (dir_t[i]) if (dir_t[i] >= tb) late++;
    checks++;
    if (late != 0) begin errors++; $display("FAIL right_release: got %0d strobes after break want 0", late); end
  endtask

  task automatic test_typematic();
    int t0, tend, bad, n;
    clear_logs();
    send_byte(8'hE0);
    send_byte(8'h6B);
    t0 = last_stop + 4;
    send_byte(8'hE0);
    send_byte(8'h6B);
    tend = last_stop + 250;
    wait_until(tend + 2);
    checks++;
    if (dir_t.size() == 0 || dir_t[0] != t0 || dir_v[0] !== 4'b0010) begin
      errors++;
      $display("FAIL left_make: got %0d strobes, first at %0d want 0010 at %0d",
               dir_t.size(), (dir_t.size() > 0) ? dir_t[0] : -1, t0);
    end
    bad = 0;
    n   = 0;
    foreach (dir_t[i]) begin
      if (dir_t[i] <= tend) begin
        n++;
        if ((dir_t[i] - t0) % REP != 0 || dir_v[i] !== 4'b0010) bad++;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL typematic_grid: got %0d off-grid strobes want 0", bad); end
    checks++;
    if (n != (tend - t0) / REP + 1) begin
      errors++;
      $display("FAIL typematic_count: got %0d strobes want %0d", n, (tend - t0) / REP + 1);
    end
  endtask

  task automatic test_left_right();
    int tm, tb, tend, bad, after, hit, tr;
    clear_logs();
    bad_dir = 1'b0;
    send_byte(8'hE0);
    send_byte(8'h74);
    tm = last_stop + 4;
    repeat (250) @(negedge clk_in);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    tb   = last_stop + 4;
    tend = tb + 250;
    wait_until(tend + 2);
    bad   = 0;
    after = 0;
    hit   = 0;
    foreach (dir_t[i]) begin
      if (dir_t[i] <= tend) begin
        if (dir_t[i] == tm && dir_v[i] === 4'b0001) hit = 1;
        if (dir_t[i] >= tb) after++;
        if (dir_v[i] !== ((dir_t[i] < tm || dir_t[i] >= tb) ? 4'b0010 : 4'b0001)) bad++;
      end
    end
    checks++;
    if (hit != 1) begin errors++; $display("FAIL right_over_left_make: got hit=%0d want 1 at %0d", hit, tm); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL left_right_values: got %0d wrong strobes want 0", bad); end
    checks++;
    if (after < 2) begin errors++; $display("FAIL left_after_right_break: got %0d strobes want >=2", after); end
    checks++;
    if (bad_dir) begin errors++; $display("FAIL direction_onehot: got multi-bit direction want one-hot"); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    tr = last_stop + 4;
    wait_until(tr + 300);
    after = 0;
    foreach (dir_t[i]) if (dir_t[i] >= tr) after++;
    checks++;
    if (after != 0) begin errors++; $display("FAIL left_release: got %0d strobes want 0", after); end
  endtask

  task automatic test_space();
    int tn;
    clear_logs();
    send_byte(8'h29);
    tn = last_stop + 4;
    repeat (20) @(negedge clk_in);
    checks++;
    if (ng_t.size() != 1 || ng_t[0] != tn) begin
      errors++;
      $display("FAIL new_game_make: got %0d pulses first at %0d want 1 at %0d",
               ng_t.size(), (ng_t.size() > 0) ? ng_t[0] : -1, tn);
    end
    send_byte(8'hF0);
    send_byte(8'h29);
    repeat (50) @(negedge clk_in);
    checks++;
    if (ng_t.size() != 1) begin errors++; $display("FAIL space_break: got %0d pulses want 1", ng_t.size()); end
    checks++;
    if (dir_t.size() != 0) begin errors++; $display("FAIL space_no_direction: got %0d strobes want 0", dir_t.size()); end
  endtask

  task automatic test_bad_parity();
    int te, tg;
    clear_logs();
    send_byte(8'hE0);
    send_frame(8'h74, 1'b1, 11);
    te = last_stop + 4;
    repeat (150) @(negedge clk_in);
    checks++;
    if (fe_t.size() != 1 || fe_t[0] != te) begin
      errors++;
      $display("FAIL parity_error: got %0d pulses first at %0d want 1 at %0d",
               fe_t.size(), (fe_t.size() > 0) ? fe_t[0] : -1, te);
    end
    checks++;
    if (dir_t.size() != 0) begin errors++; $display("FAIL parity_no_strobe: got %0d strobes want 0", dir_t.size()); end
    // The extended prefix is still pending, so a clean 0x74 is a right make.
    send_byte(8'h74);
    tg = last_stop + 4;
    repeat (20) @(negedge clk_in);
    checks++;
    if (dir_t.size() != 1 || dir_t[0] != tg || dir_v[0] !== 4'b0001) begin
      errors++;
      $display("FAIL ext_survives_error: got %0d strobes first at %0d want 0001 at %0d",
               dir_t.size(), (dir_t.size() > 0) ? dir_t[0] : -1, tg);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
  endtask

  task automatic test_timeout();
    int l, tn;
    clear_logs();
    send_frame(8'h74, 1'b0, 5);
    ps2_data = 1'b1;
    l = last_drop;
    wait_until(l + 260);
    checks++;
    if (fe_t.size() != 1 || fe_t[0] < l + TO - 5 || fe_t[0] > l + TO + 15) begin
      errors++;
      $display("FAIL timeout_error: got %0d pulses first at %0d want 1 near %0d",
               fe_t.size(), (fe_t.size() > 0) ? fe_t[0] : -1, l + TO);
    end
    send_byte(8'h29);
    tn = last_stop + 4;
    repeat (20) @(negedge clk_in);
    checks++;
    if (ng_t.size() != 1 || ng_t[0] != tn || fe_t.size() != 1) begin
      errors++;
      $display("FAIL after_timeout_frame: got %0d new_game %0d errors want 1 at %0d and 1",
               ng_t.size(), fe_t.size(), tn);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    int tg;
    clear_logs();
    send_byte(8'hE0);
    send_byte(8'h74);
    send_frame(8'h6B, 1'b0, 4);
    ps2_data = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 150 && !found; i++) begin
      @(negedge clk_in);
      if (direction != 4'b0000) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL held_strobe_wait: got no strobe in 150 cycles want one"); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (direction !== 4'b0000 || new_game !== 1'b0 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_clear: got dir=%b ng=%b fe=%b want 0000 0 0", direction, new_game, frame_error);
    end
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    clear_logs();
    repeat (400) @(negedge clk_in);
    checks++;
    if (dir_t.size() + ng_t.size() + fe_t.size() != 0) begin
      errors++;
      $display("FAIL after_reset_quiet: got %0d dir %0d ng %0d fe want 0",
               dir_t.size(), ng_t.size(), fe_t.size());
    end
    send_byte(8'hE0);
    send_byte(8'h74);
    tg = last_stop + 4;
    repeat (20) @(negedge clk_in);
    checks++;
    if (dir_t.size() != 1 || dir_t[0] != tg || dir_v[0] !== 4'b0001) begin
      errors++;
      $display("FAIL fresh_decode: got %0d strobes first at %0d want 0001 at %0d",
               dir_t.size(), (dir_t.size() > 0) ? dir_t[0] : -1, tg);
    end
  endtask

  initial begin
    // NOTE: inputs change on the falling clock edge so the DUT never sees a
    // same-edge race with the stimulus.
    test_reset();
    test_right_repeat();
    test_typematic();
    test_left_right();
    test_space();
    test_bad_parity();
    test_timeout();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_direction_encoder.md
# ps2_direction_encoder

Front end that turns a PS/2 keyboard into the one-hot `direction` command stream and `new_game` pulse consumed by the bar and game FSMs. It receives PS/2 frames and decodes arrow make/break sequences into a held-key set. While a key is held, it emits single-cycle direction strobes at a fixed repeat rate. It sits between the board PS/2 pins and the game-logic modules, all in the `clk_in` domain.

## Interface
- `REPEAT_CYCLES`, default 500000: clk_in cycles between successive direction strobes while a key is held.
- `TIMEOUT_CYCLES`, default 50000: cycles without a PS/2 falling edge after which a partial frame is discarded.
- `clk_in`  input  1  system clock; all logic on posedge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `ps2_clk`  input  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  input  1  raw PS/2 data pin, asynchronous.
- `direction`  output  4  one-hot strobe: 0001 right, 0010 left, 0100 up, 1000 down, 0000 idle.
- `new_game`  output  1  one-cycle strobe on space-bar make (0x29).
- `frame_error`  output  1  one-cycle strobe on parity, start or stop bit failure, or on timeout.

## Operation
- Both PS/2 pins pass through a 2-FF synchronizer. A falling edge is detected on synchronized `ps2_clk` (previous=1, current=0).
- Receiver states: IDLE, SHIFT, CHECK.
  - IDLE: on an edge with data=0 (start bit), go to SHIFT with bit count 0. An edge with data=1 raises `frame_error`, and the state stays IDLE.
  - SHIFT: capture 8 data bits LSB first, then the parity bit. After the 9th capture, go to CHECK.
  - CHECK: on the next edge, sample the stop bit. Accept the byte only if the stop bit is 1 and the data plus parity bits have odd parity; otherwise raise `frame_error`. Return to IDLE either way.
- Timeout: an edge counter restarts on every falling edge. In SHIFT or CHECK, reaching TIMEOUT_CYCLES returns the receiver to IDLE, pulses `frame_error`, and drops the partial byte.
- Decoder flags `ext` (after 0xE0) and `brk` (after 0xF0) latch until the next non-prefix byte, which consumes and clears both.
- Key map:
  - With `ext`: 0x74 right, 0x6B left, 0x75 up, 0x72 down.
  - Without `ext`: 0x29 space.
  - Any other code clears the flags with no further effect.
- Arrow make: if the key's bit in `held[3:0]` is 0, set it and issue an immediate strobe. If the bit is already 1 (keyboard typematic repeat), do nothing.
- Arrow break: clear the key's `held` bit; no strobe.
- Repeat: while `held` is nonzero, a repeat counter runs. On reaching REPEAT_CYCLES-1, emit a strobe and wrap to 0. The counter resets to 0 on every immediate strobe, and when `held` becomes 0.
- Strobe value: the most recently pressed key still held (tracked in a `last` register). On break of `last`, `last` moves to the lowest-index remaining held bit, or none.
- Left and right both held: strobe value is `last`, never both bits. `direction` is always one-hot or zero.
- Space make: `new_game`=1 for one cycle. Space break is ignored.

## Timing
- Reset values: `direction`=0000, `new_game`=0, `frame_error`=0, `held`=0, flags=0, receiver state IDLE, all counters 0.
- Pin-to-edge latency: 3 cycles (2 synchronizer stages plus edge register).
- Byte accepted on the stop-bit edge cycle N. The decoder acts at N+1, and `direction`/`new_game` are registered high during N+1 only.
- Repeat strobes follow at N+1+k·REPEAT_CYCLES while the key stays held.
- `frame_error` is high during the cycle after the failing edge, or after timeout detection.
- All outputs are registered and hold each strobe for exactly 1 cycle.
- Reset asserted mid-frame or with keys held: outputs clear immediately and asynchronously. After reset release, decoding starts fresh in IDLE. Any stale partial frame is lost or rejected by timeout or parity.
- Simultaneous repeat-tick and make events in one cycle: the make strobe wins, and the repeat counter resets.

## Test plan
- Send E0 74 (right make) with REPEAT_CYCLES=100 → `direction`=0001 for 1 cycle at N+1, then 0001 every 100 cycles. Send E0 F0 74 → no further strobes, `held`=0.
- Send E0 6B, then E0 6B again (typematic) → exactly one immediate 0010 strobe, and repeat spacing stays unchanged.
- Hold left, then press right, then release right → strobes switch from 0010 to 0001 after the right make, then back to 0010 after the right break. Never 0011.
- Send 0x29 → `new_game` pulse of 1 cycle. Send F0 29 → nothing.
- Send a frame with bad parity (0x74 with parity=0) → `frame_error` pulse, no strobe. Send a frame that stops after 5 bits with TIMEOUT_CYCLES=200 → `frame_error` about 200 cycles after the last edge, and the next valid frame decodes correctly.
- Assert reset during bit 4 of a frame while right is held → all outputs 0 immediately, no strobes after release.
